// File: rtl/split_var_arbiter_sc.sv
// split_var_arbiter_sc: round-robin arbiter sequencing two requesters onto one split-variable datapath
module split_var_arbiter_sc #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clock_sc,
    input  logic       rst_n_sc,
    input  logic       req_a_sc,
    input  logic       req_b_sc,
    input  logic       data_a_sc,
    input  logic       en_a_sc,
    input  logic       data_b_sc,
    input  logic       en_b_sc,
    output logic       gnt_a_sc,
    output logic       gnt_b_sc,
    output logic       busy_sc,
    output logic       owner_sc,
    output logic       done_sc,
    output logic [1:0] data_split_out_sc,
    output logic       state_out_sc
);
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("HOLD_CYCLES must be in 1..15");
    end
    typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;
    state_t     fsm;
    logic [3:0] cnt;
    logic       last_owner;
    logic       op_d;
    logic       op_e;
    logic       win;
    logic       pick_b;
    // B wins when alone, or when both request and A owned the previous transaction
    always_comb begin
        win    = req_a_sc | req_b_sc;
        pick_b = req_b_sc & (~req_a_sc | ~last_owner);
    end
    // Sequencer: arbitrate in IDLE, load the datapath once, hold, then report completion
    always_ff @(posedge clock_sc or negedge rst_n_sc) begin
        if (!rst_n_sc) begin
            fsm               <= IDLE;
            cnt               <= 4'd0;
            last_owner        <= 1'b1;
            op_d              <= 1'b0;
            op_e              <= 1'b0;
            gnt_a_sc          <= 1'b0;
            gnt_b_sc          <= 1'b0;
            busy_sc           <= 1'b0;
            owner_sc          <= 1'b0;
            done_sc           <= 1'b0;
            data_split_out_sc <= 2'b00;
            state_out_sc      <= 1'b0;
        end else begin
            gnt_a_sc <= 1'b0;
            gnt_b_sc <= 1'b0;
            done_sc  <= 1'b0;
            case (fsm)
                IDLE: begin
                    busy_sc <= win;
                    if (win) begin
                        owner_sc <= pick_b;
                        gnt_a_sc <= ~pick_b;
                        gnt_b_sc <= pick_b;
                        op_d     <= pick_b ? data_b_sc : data_a_sc;
                        op_e     <= pick_b ? en_b_sc : en_a_sc;
                        fsm      <= LOAD;
                    end
                end
                LOAD: begin
                    data_split_out_sc <= {op_d | op_e, op_d & op_e};
                    state_out_sc      <= state_out_sc ^ (op_d | op_e);
                    cnt               <= 4'(HOLD_CYCLES - 1);
                    fsm               <= (HOLD_CYCLES > 1) ? HOLD : DONE;
                end
                HOLD: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) fsm <= DONE;
                end
                DONE: begin
                    done_sc    <= 1'b1;
                    last_owner <= owner_sc;
                    fsm        <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_split_var_arbiter_sc.sv
// tb_split_var_arbiter_sc: directed vector and sequence checks of the split-variable arbiter
module tb_split_var_arbiter_sc;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ra = 1'b0, rb = 1'b0, da = 1'b0, ea = 1'b0, db = 1'b0, eb = 1'b0;
    logic ga0, gb0, bsy0, own0, dn0, st0;
    logic [1:0] sp0;
    logic ga1, gb1, bsy1, own1, dn1, st1;
    logic [1:0] sp1;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [5:0] in;
        logic [7:0] out;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    split_var_arbiter_sc #(.HOLD_CYCLES(2)) u0 (
        .clock_sc(clk), .rst_n_sc(rst_n),
        .req_a_sc(ra), .req_b_sc(rb),
        .data_a_sc(da), .en_a_sc(ea), .data_b_sc(db), .en_b_sc(eb),
        .gnt_a_sc(ga0), .gnt_b_sc(gb0), .busy_sc(bsy0), .owner_sc(own0),
        .done_sc(dn0), .data_split_out_sc(sp0), .state_out_sc(st0)
    );

    split_var_arbiter_sc #(.HOLD_CYCLES(1)) u1 (
        .clock_sc(clk), .rst_n_sc(rst_n),
        .req_a_sc(ra), .req_b_sc(rb),
        .data_a_sc(da), .en_a_sc(ea), .data_b_sc(db), .en_b_sc(eb),
        .gnt_a_sc(ga1), .gnt_b_sc(gb1), .busy_sc(bsy1), .owner_sc(own1),
        .done_sc(dn1), .data_split_out_sc(sp1), .state_out_sc(st1)
    );

    function automatic logic [7:0] outs0();
        return {ga0, gb0, bsy0, own0, dn0, sp0, st0};
    endfunction

    function automatic logic [7:0] outs1();
        return {ga1, gb1, bsy1, own1, dn1, sp1, st1};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_u0", outs0(), 8'h00);
        chk("rst_async_u1", outs1(), 8'h00);
        repeat (2) tick();
        chk("rst_held_u0", outs0(), 8'h00);
        {ra, rb, da, ea, db, eb} = 6'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int ngnt;
        logic [3:0] order;
        // {ra rb da ea db eb} -> {gnt_a gnt_b busy owner done split[1:0] state}
        tbl[0] = '{6'b101000, 8'b10100000};
        tbl[1] = '{6'b000000, 8'b00100101};
        tbl[2] = '{6'b000000, 8'b00100101};
        tbl[3] = '{6'b000000, 8'b00101101};
        tbl[4] = '{6'b000000, 8'b00000101};
        tbl[5] = '{6'b010011, 8'b01110101};
        tbl[6] = '{6'b000000, 8'b00110110};
        tbl[7] = '{6'b000000, 8'b00110110};
        tbl[8] = '{6'b000000, 8'b00111110};
        tbl[9] = '{6'b000000, 8'b00010110};

        {ra, rb, da, ea, db, eb} = 6'b111111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_u0", outs0(), 8'h00);
        chk("reset_async_u1", outs1(), 8'h00);
        repeat (3) tick();
        chk("reset_held_u0", outs0(), 8'h00);
        {ra, rb, da, ea, db, eb} = 6'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_release_u0", outs0(), 8'h00);

        for (int i = 0; i < 10; i++) begin
            {ra, rb, da, ea, db, eb} = tbl[i].in;
            tick();
            chk($sformatf("vec%0d", i), outs0(), tbl[i].out);
        end

        ngnt = 0;
        order = 4'b0;
        ra = 1'b1;
        rb = 1'b1;
        for (int k = 0; k < 17; k++) begin
            da = k[0];
            db = k[1];
            tick();
            chk($sformatf("one_gnt_c%0d", k), {7'b0, ga0 & gb0}, 8'h00);
            if (ga0 | gb0) begin
                if (ngnt < 4) order[ngnt] = gb0;
                ngnt++;
            end
            if (k == 12) begin
                ra = 1'b0;
                rb = 1'b0;
            end
        end
        chk("contend_count", 8'(ngnt), 8'd4);
        chk("contend_order", {4'b0, order}, 8'b00001010);
        chk("contend_idle", {7'b0, bsy0}, 8'h00);

        da = 1'b1;
        ea = 1'b0;
        ra = 1'b1;
        tick();
        ra = 1'b0;
        tick();
        chk("mid_load_split", {6'b0, sp0}, 8'b00000010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_async", outs0(), 8'h00);
        tick();
        chk("mid_rst_no_done", outs0(), 8'h00);
        tick();
        chk("mid_rst_no_done2", outs0(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        ra = 1'b1;
        rb = 1'b1;
        da = 1'b0;
        tick();
        chk("after_rst_a_first", outs0(), 8'b10100000);
        ra = 1'b0;
        rb = 1'b0;
        repeat (6) tick();

        do_reset();
        ra = 1'b1;
        da = 1'b1;
        ea = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("h1_gnt_c%0d", k), {7'b0, ga1}, {7'b0, k % 3 == 0});
            chk($sformatf("h1_done_c%0d", k), {7'b0, dn1}, {7'b0, k % 3 == 2});
            chk($sformatf("h1_busy_c%0d", k), {7'b0, bsy1}, 8'h01);
            if (k == 1) chk("h1_split", {6'b0, sp1}, 8'b00000011);
        end
        ra = 1'b0;
        repeat (4) tick();
        chk("h1_idle", {7'b0, bsy1}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
